iir_decimator: RTL

Decimating output buffer placed directly downstream of the cascaded-SOS IIR low-pass filter. Consumes the filter's 18-bit `dv_out`/`d_out` sample stream and keeps one sample in every `Ndec`. Kept samples go into a small first-word-fall-through FIFO, which presents them to the consumer over a valid/ready handshake. FIFO overrun is flagged with a sticky, software-clearable status bit.

---
 rtl/iir_decimator.sv | 104 ++++++++++
 1 files changed

// File: rtl/iir_decimator.sv
// Keeps one IIR output sample in every Ndec and buffers it in a first-word-fall-through FIFO.
// Latency: a kept sample pushed into an empty FIFO appears on m_valid/m_data the next cycle.
// Backpressure: m_ready stalls the head; the input cannot be stalled, so a kept sample that meets a full FIFO with no pop is dropped and flagged on sticky overflow.
module iir_decimator #(
    parameter int Ndec  = 4,
    parameter int Depth = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dv_in,
    input  logic [17:0]              d_in,
    output logic                     m_valid,
    output logic [17:0]              m_data,
    input  logic                     m_ready,
    output logic [$clog2(Depth):0]   fill,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(Depth);
    localparam int PW = (Ndec > 1) ? $clog2(Ndec) : 1;

    localparam logic [PW-1:0] PH_LAST = PW'(Ndec - 1);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [AW:0]   FULL    = (AW + 1)'(Depth);
    localparam logic [AW:0]   ONE     = (AW + 1)'(1);

    logic [PW-1:0] r_ph;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_fill;
    logic          r_ovf;
    logic [17:0]   r_mem [Depth];

    logic w_keep;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // A full FIFO still accepts a kept sample when the head leaves in the same cycle.
    assign w_empty = (r_fill == '0);
    assign w_full  = (r_fill == FULL);
    assign w_pop   = !w_empty && m_ready;
    assign w_keep  = dv_in && (r_ph == '0);
    assign w_push  = w_keep && (!w_full || w_pop);
    assign w_drop  = w_keep && w_full && !w_pop;

    // Decimation phase advances on every input strobe, kept or dropped, so drops never shift the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph <= '0;
        end else if (dv_in) begin
            r_ph <= (r_ph == PH_LAST) ? '0 : r_ph + PH_ONE;
        end
    end

    // Read/write pointers carry a wrap bit; occupancy is tracked explicitly for the fill output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + ONE;
                2'b01:   r_fill <= r_fill - ONE;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Sample storage; contents need no reset because an empty FIFO masks the read port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= d_in;
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Outputs decode registered state only; m_ready has no path to m_valid or m_data.
    assign m_valid  = !w_empty;
    assign m_data   = w_empty ? 18'h0 : r_mem[r_rd_ptr[AW-1:0]];
    assign fill     = r_fill;
    assign overflow = r_ovf;

endmodule
